// File: rtl/id_stage_hz_pkg.sv
// Shared definitions for the ID stage slice.
//   - default sizing constants for data width, register count, opcode width
//   - opcode_t : instruction opcode encoding (0x00..0x11 defined)
//   - id_state_t : decode-stage control state
//   - id_ex_t : ID->EX bundle layout at the default sizing
//   - is_defined_op : true for opcodes the decoder recognises
package id_stage_hz_pkg;

  localparam int unsigned D_SIZE_DEF    = 32;
  localparam int unsigned NUM_REGS_DEF  = 32;
  localparam int unsigned ADDR_LINE_DEF = $clog2(NUM_REGS_DEF);
  localparam int unsigned OPC_W_DEF     = 6;

  typedef enum logic [5:0] {
    OP_ADD  = 6'h00, OP_ADDI = 6'h01, OP_SUB  = 6'h02, OP_SUBI = 6'h03,
    OP_MUL  = 6'h04, OP_MULI = 6'h05, OP_OR   = 6'h06, OP_ORI  = 6'h07,
    OP_AND  = 6'h08, OP_ANDI = 6'h09, OP_XOR  = 6'h0A, OP_XORI = 6'h0B,
    OP_LDW  = 6'h0C, OP_STW  = 6'h0D, OP_BZ   = 6'h0E, OP_BEQ  = 6'h0F,
    OP_JR   = 6'h10, OP_HALT = 6'h11
  } opcode_t;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } id_state_t;

  typedef struct packed {
    logic [OPC_W_DEF-1:0]     opcode;
    logic [D_SIZE_DEF-1:0]    rs_value;
    logic [D_SIZE_DEF-1:0]    rt_value;
    logic [ADDR_LINE_DEF-1:0] rd_addr;
    logic [D_SIZE_DEF-1:0]    i_data;
  } id_ex_t;

  function automatic logic is_defined_op(input logic [5:0] op);
    return op <= 6'(OP_HALT);
  endfunction

endpackage

// File: rtl/id_regfile.sv
// Two-read / one-write register file for the decode stage.
//   clk, reset        : clock, synchronous active-high reset (clears all regs)
//   rs_addr, rt_addr  : read indices
//   rs_data, rt_data  : combinational read data (reg 0 always reads 0)
//   w_en, w_addr,
//   w_data            : write port, applied on clk when w_en && w_addr != 0
// A read of the address being written in the same cycle returns w_data.
module id_regfile
  import id_stage_hz_pkg::*;
#(
  parameter int unsigned D_SIZE   = D_SIZE_DEF,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  localparam int unsigned ADDR_LINE = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_LINE-1:0] rs_addr,
  input  logic [ADDR_LINE-1:0] rt_addr,
  output logic [D_SIZE-1:0]    rs_data,
  output logic [D_SIZE-1:0]    rt_data,
  input  logic                 w_en,
  input  logic [ADDR_LINE-1:0] w_addr,
  input  logic [D_SIZE-1:0]    w_data
);

  logic [D_SIZE-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (w_en && w_addr != '0) begin
      regs[w_addr] <= w_data;
    end
  end

  assign rs_data = (rs_addr == '0)                 ? '0     :
                   (w_en && w_addr == rs_addr)     ? w_data : regs[rs_addr];
  assign rt_data = (rt_addr == '0)                 ? '0     :
                   (w_en && w_addr == rt_addr)     ? w_data : regs[rt_addr];

endmodule

// File: rtl/id_stage_hz.sv
// Instruction decode stage between IF and EX.
//   clk, reset           : clock, synchronous active-high reset
//   valid, inst          : instruction from IF; ready_2_if says it is taken
//   w_f_wb, addr_in_f_wb,
//   write_data_f_wb      : writeback port into the register file
//   ready_f_ex           : EX accepts the current output bundle
//   valid_2_ex ..
//   i_data_2_ex          : registered decoded bundle to EX
//   halted               : HALT accepted, stage frozen until reset
// Load-use hazards against the LDW held in the output register stall IF
// for one cycle and send a bubble to EX.
module id_stage_hz
  import id_stage_hz_pkg::*;
#(
  parameter int unsigned D_SIZE   = D_SIZE_DEF,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned OPC_W    = OPC_W_DEF,
  localparam int unsigned ADDR_LINE = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid,
  input  logic [31:0]          inst,
  output logic                 ready_2_if,
  input  logic                 w_f_wb,
  input  logic [ADDR_LINE-1:0] addr_in_f_wb,
  input  logic [D_SIZE-1:0]    write_data_f_wb,
  input  logic                 ready_f_ex,
  output logic                 valid_2_ex,
  output logic [OPC_W-1:0]     opcode_2_ex,
  output logic [D_SIZE-1:0]    rs_reg_value_2_ex,
  output logic [D_SIZE-1:0]    rt_reg_value_2_ex,
  output logic [ADDR_LINE-1:0] rd_addr_2_ex,
  output logic [D_SIZE-1:0]    i_data_2_ex,
  output logic                 halted
);

  id_state_t state;

  opcode_t              op;
  logic [ADDR_LINE-1:0] rs_idx, rt_idx, rd_idx;
  logic [D_SIZE-1:0]    rs_val, rt_val, sext_imm;
  logic [ADDR_LINE-1:0] dec_dest;
  logic [D_SIZE-1:0]    dec_imm;
  logic                 dec_valid;
  logic                 hazard, advance, accept;

  assign op       = opcode_t'(inst[31:26]);
  assign rs_idx   = inst[21 +: ADDR_LINE];
  assign rt_idx   = inst[16 +: ADDR_LINE];
  assign rd_idx   = inst[11 +: ADDR_LINE];
  assign sext_imm = {{(D_SIZE-16){inst[15]}}, inst[15:0]};

  id_regfile #(
    .D_SIZE   (D_SIZE),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .rs_addr (rs_idx),
    .rt_addr (rt_idx),
    .rs_data (rs_val),
    .rt_data (rt_val),
    .w_en    (w_f_wb),
    .w_addr  (addr_in_f_wb),
    .w_data  (write_data_f_wb)
  );

  always_comb begin
    dec_dest  = '0;
    dec_imm   = '0;
    dec_valid = 1'b1;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_AND, OP_XOR: dec_dest = rd_idx;
      OP_ADDI, OP_SUBI, OP_MULI, OP_ORI, OP_ANDI, OP_XORI, OP_LDW: begin
        dec_dest = rt_idx;
        dec_imm  = sext_imm;
      end
      OP_STW, OP_BZ, OP_BEQ, OP_JR: dec_imm = sext_imm;
      OP_HALT: ;
      default: dec_valid = 1'b0;
    endcase
  end

  // Only a valid LDW still sitting in the output register can create a
  // load-use conflict; its result is not yet in the register file.
  assign hazard  = valid_2_ex && (opcode_2_ex == OPC_W'(OP_LDW)) &&
                   (rd_addr_2_ex != '0) &&
                   ((rd_addr_2_ex == rs_idx) || (rd_addr_2_ex == rt_idx));
  assign advance    = !valid_2_ex || ready_f_ex;
  assign ready_2_if = (state == ST_RUN) && advance && !hazard;
  assign accept     = valid && ready_2_if;

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= ST_RUN;
      halted            <= 1'b0;
      valid_2_ex        <= 1'b0;
      opcode_2_ex       <= '0;
      rs_reg_value_2_ex <= '0;
      rt_reg_value_2_ex <= '0;
      rd_addr_2_ex      <= '0;
      i_data_2_ex       <= '0;
    end else begin
      if (accept && op == OP_HALT) begin
        state  <= ST_HALTED;
        halted <= 1'b1;
      end
      if (advance) begin
        if (accept) begin
          valid_2_ex        <= dec_valid;
          opcode_2_ex       <= OPC_W'(inst[31:26]);
          rs_reg_value_2_ex <= rs_val;
          rt_reg_value_2_ex <= rt_val;
          rd_addr_2_ex      <= dec_dest;
          i_data_2_ex       <= dec_imm;
        end else begin
          valid_2_ex        <= 1'b0;
          opcode_2_ex       <= '0;
          rs_reg_value_2_ex <= '0;
          rt_reg_value_2_ex <= '0;
          rd_addr_2_ex      <= '0;
          i_data_2_ex       <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_id_stage_hz.sv
module tb_id_stage_hz;
  import id_stage_hz_pkg::*;

  logic        clk = 1'b0;
  logic        reset, valid, ready_2_if, w_f_wb, ready_f_ex, valid_2_ex, halted;
  logic [31:0] inst, write_data_f_wb, rs_reg_value_2_ex, rt_reg_value_2_ex, i_data_2_ex;
  logic [4:0]  addr_in_f_wb, rd_addr_2_ex;
  logic [5:0]  opcode_2_ex;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: architectural registers, expected EX bundle, halt flag
  logic [31:0] m_rf [32];
  logic        m_v;
  id_ex_t      m_ex;
  bit          m_halt;

  always #5 clk = ~clk;

  id_stage_hz #(.D_SIZE(32), .NUM_REGS(32), .OPC_W(6)) dut (
    .clk(clk), .reset(reset), .valid(valid), .inst(inst), .ready_2_if(ready_2_if),
    .w_f_wb(w_f_wb), .addr_in_f_wb(addr_in_f_wb), .write_data_f_wb(write_data_f_wb),
    .ready_f_ex(ready_f_ex), .valid_2_ex(valid_2_ex), .opcode_2_ex(opcode_2_ex),
    .rs_reg_value_2_ex(rs_reg_value_2_ex), .rt_reg_value_2_ex(rt_reg_value_2_ex),
    .rd_addr_2_ex(rd_addr_2_ex), .i_data_2_ex(i_data_2_ex), .halted(halted)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_load_use(input logic [31:0] i);
    return m_v && m_ex.opcode == 6'(OP_LDW) && m_ex.rd_addr != 0 &&
           (m_ex.rd_addr == i[25:21] || m_ex.rd_addr == i[20:16]);
  endfunction

  function automatic bit m_ready(input logic [31:0] i, input logic rf_ex);
    return !m_halt && !(m_v && !rf_ex) && !m_load_use(i);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r, input logic w,
                                         input logic [4:0] wa, input logic [31:0] wd);
    if (r == 0) return 32'h0;
    if (w && wa == r) return wd;
    return m_rf[r];
  endfunction

  task automatic m_reset();
    foreach (m_rf[k]) m_rf[k] = 32'h0;
    m_v    = 1'b0;
    m_ex   = '0;
    m_halt = 1'b0;
  endtask

  task automatic model_step(input logic rst, input logic v, input logic [31:0] i,
                            input logic w, input logic [4:0] wa, input logic [31:0] wd,
                            input logic rf_ex);
    logic [5:0]  op;
    logic [31:0] sx;
    bit          busy, take;
    if (rst) begin
      m_reset();
      return;
    end
    op   = i[31:26];
    sx   = {{16{i[15]}}, i[15:0]};
    busy = m_v && !rf_ex;
    take = v && m_ready(i, rf_ex);
    if (take) begin
      m_v = (op <= 6'h11);
      m_ex.opcode   = op;
      m_ex.rs_value = m_read(i[25:21], w, wa, wd);
      m_ex.rt_value = m_read(i[20:16], w, wa, wd);
      if (op <= 6'h0B) begin
        m_ex.rd_addr = op[0] ? i[20:16] : i[15:11];
        m_ex.i_data  = op[0] ? sx : 32'h0;
      end else if (op == 6'h0C) begin
        m_ex.rd_addr = i[20:16];
        m_ex.i_data  = sx;
      end else if (op <= 6'h10) begin
        m_ex.rd_addr = 5'h0;
        m_ex.i_data  = sx;
      end else begin
        m_ex.rd_addr = 5'h0;
        m_ex.i_data  = 32'h0;
      end
      if (op == 6'h11) m_halt = 1'b1;
    end else if (!busy) begin
      m_v = 1'b0;
    end
    if (w && wa != 0) m_rf[wa] = wd;
  endtask

  task automatic compare_outputs();
    check("valid_2_ex", valid_2_ex, m_v);
    check("halted", halted, m_halt);
    check("ready_2_if", ready_2_if, m_ready(inst, ready_f_ex));
    if (m_v) begin
      check("opcode", opcode_2_ex, m_ex.opcode);
      check("rs_value", rs_reg_value_2_ex, m_ex.rs_value);
      check("rt_value", rt_reg_value_2_ex, m_ex.rt_value);
      check("rd_addr", rd_addr_2_ex, m_ex.rd_addr);
      check("i_data", i_data_2_ex, m_ex.i_data);
    end
  endtask

  // Drive one cycle of inputs, check pre-edge outputs, advance model and clock.
  task automatic cycle(input logic v, input logic [31:0] i, input logic w,
                       input logic [4:0] wa, input logic [31:0] wd,
                       input logic rf_ex, input logic rst);
    reset = rst; valid = v; inst = i; w_f_wb = w;
    addr_in_f_wb = wa; write_data_f_wb = wd; ready_f_ex = rf_ex;
    #2;
    compare_outputs();
    model_step(rst, v, i, w, wa, wd, rf_ex);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0]  op;
    logic [31:0] ri;
    int          r;

    reset = 1'b1; valid = 1'b0; inst = '0; w_f_wb = 1'b0;
    addr_in_f_wb = '0; write_data_f_wb = '0; ready_f_ex = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_reset();
    check("reset_valid", valid_2_ex, 1'b0);
    check("reset_halted", halted, 1'b0);

    // ADDI r1,r0,-5
    cycle(1, 32'h0401FFFB, 0, 0, 0, 1, 0);
    check("addi_valid", valid_2_ex, 1'b1);
    check("addi_rd", rd_addr_2_ex, 5'd1);
    check("addi_imm", i_data_2_ex, 32'hFFFFFFFB);

    // ADD r4,r3,r3 while WB writes r3
    cycle(1, 32'h00632000, 1, 5'd3, 32'hA5A5A5A5, 1, 0);
    check("bypass_rs", rs_reg_value_2_ex, 32'hA5A5A5A5);
    check("bypass_rt", rt_reg_value_2_ex, 32'hA5A5A5A5);

    // write to r0 is dropped
    cycle(0, 32'h0, 1, 5'd0, 32'h0000FFFF, 1, 0);
    cycle(1, 32'h00002800, 0, 0, 0, 1, 0);
    check("r0_read", rs_reg_value_2_ex, 32'h0);

    // LDW r2,0(r1) then ADD r5,r2,r1
    cycle(1, 32'h30220000, 0, 0, 0, 1, 0);
    cycle(1, 32'h00412800, 0, 0, 0, 1, 0);
    check("loaduse_bubble", valid_2_ex, 1'b0);
    cycle(1, 32'h00412800, 0, 0, 0, 1, 0);
    check("loaduse_issue", valid_2_ex, 1'b1);
    check("loaduse_rd", rd_addr_2_ex, 5'd5);

    // EX back-pressure for 3 cycles
    cycle(1, 32'h04020007, 0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(1, 32'h00A33000, 0, 0, 0, 0, 0);
      check("stall_imm", i_data_2_ex, 32'h7);
      check("stall_ready", ready_2_if, 1'b0);
    end
    cycle(1, 32'h00A33000, 0, 0, 0, 1, 0);
    check("resume_rd", rd_addr_2_ex, 5'd6);

    // HALT
    cycle(1, 32'h44000000, 0, 0, 0, 1, 0);
    check("halt_flag", halted, 1'b1);
    check("halt_issued", opcode_2_ex, 6'h11);
    cycle(1, 32'h00412800, 1, 5'd7, 32'h1234, 1, 0);
    check("halt_drained", valid_2_ex, 1'b0);
    check("halt_ready", ready_2_if, 1'b0);

    cycle(0, 32'h0, 0, 0, 0, 1, 1);
    check("rst_halted", halted, 1'b0);
    check("rst_valid", valid_2_ex, 1'b0);
    check("rst_imm", i_data_2_ex, 32'h0);

    // Randomised traffic over a small register window to provoke hazards
    for (int n = 0; n < 4000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 2)       op = 6'h11;
      else if (r < 6)  op = 6'($urandom_range(18, 63));
      else if (r < 26) op = 6'h0C;
      else             op = 6'($urandom_range(0, 16));
      ri = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 11'($urandom)};
      cycle(($urandom_range(0, 3) != 0), ri, 1'($urandom), 5'($urandom_range(0, 3)),
            $urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) < 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
